// File: rtl/synth_pkg.sv
// Shared synth types: mode encoding used by the mode selector and the display decoder.
package synth_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_0 = 2'd0;
   localparam mode_t MODE_1 = 2'd1;
   localparam mode_t MODE_2 = 2'd2;
   localparam mode_t MODE_3 = 2'd3;

   localparam int NUM_MODES_DEFAULT = 4;

endpackage

// File: rtl/mode_selector_if.sv
// Front-panel key inputs and the resulting mode/strobe outputs of the mode selector.
interface mode_selector_if;
   import synth_pkg::*;

   logic  key_next_n;
   logic  key_prev_n;
   mode_t mode;
   logic  mode_changed;

   modport master (
      output key_next_n,
      output key_prev_n,
      input  mode,
      input  mode_changed
   );

   modport slave (
      input  key_next_n,
      input  key_prev_n,
      output mode,
      output mode_changed
   );

endinterface

// File: rtl/mode_selector_key_debounce.sv
// One pushbutton: 2-flop synchroniser, level debouncer and one-cycle press pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1   <= key_n;
         sync2   <= sync1;
         level_d <= level;
         // press fires one edge after the debounced level falls; release is ignored
         press   <= level_d & ~level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mode_selector.sv
// Steps the panel mode on debounced next/prev presses, wrapping at both ends.
module mode_selector
   import synth_pkg::*;
#(
   parameter int    DEBOUNCE_CYCLES = 500000,
   parameter int    NUM_MODES       = NUM_MODES_DEFAULT,
   parameter mode_t RESET_MODE      = MODE_0
) (
   input  logic            clk,
   input  logic            reset,
   mode_selector_if.slave  bus
);

   localparam mode_t LAST_MODE = mode_t'(NUM_MODES - 1);

   logic  press_next;
   logic  press_prev;
   mode_t mode_q;
   mode_t mode_nxt;
   logic  changed_q;
   logic  step;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk   (clk),
      .reset (reset),
      .key_n (bus.key_next_n),
      .press (press_next)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
      .clk   (clk),
      .reset (reset),
      .key_n (bus.key_prev_n),
      .press (press_prev)
   );

   // Simultaneous presses cancel; wrap is explicit so NUM_MODES<4 never leaves range
   always_comb begin
      mode_nxt = mode_q;
      step     = 1'b0;
      if (press_next && !press_prev) begin
         step     = 1'b1;
         mode_nxt = (mode_q == LAST_MODE) ? MODE_0 : mode_q + mode_t'(1);
      end else if (press_prev && !press_next) begin
         step     = 1'b1;
         mode_nxt = (mode_q == MODE_0) ? LAST_MODE : mode_q - mode_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q    <= RESET_MODE;
         changed_q <= 1'b0;
      end else begin
         mode_q    <= mode_nxt;
         changed_q <= step;
      end
   end

   assign bus.mode         = mode_q;
   assign bus.mode_changed = changed_q;

endmodule

// File: tb/tb_mode_selector.sv
// Directed and random key stimulus on two selector configurations, checked against a timeline model.
module tb_mode_selector;
   import synth_pkg::*;

   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset;
   logic raw_n;
   logic raw_p;

   always #5 clk = ~clk;

   mode_selector_if bus_a ();
   mode_selector_if bus_b ();

   assign bus_a.key_next_n = raw_n;
   assign bus_a.key_prev_n = raw_p;
   assign bus_b.key_next_n = raw_n;
   assign bus_b.key_prev_n = raw_p;

   mode_selector #(.DEBOUNCE_CYCLES(DC), .NUM_MODES(4), .RESET_MODE(MODE_0)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   mode_selector #(.DEBOUNCE_CYCLES(DC), .NUM_MODES(3), .RESET_MODE(MODE_2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Reference: keys described by timestamps, modes by modular arithmetic
   int nm[2] = '{4, 3};
   int rm[2] = '{0, 2};
   int m[2];
   int chg[2];
   int s1[2];
   int s2[2];
   int deb[2];
   int last_agree[2];
   int fell[2];
   int press[2];
   int edge_no = 0;

   int cyc = 0;
   int pulses_a = 0;
   int first_pulse = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic kn, input logic kp);
      int raw[2];
      raw[0] = int'(kn);
      raw[1] = int'(kp);
      edge_no++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m[d]   = rm[d];
            chg[d] = 0;
         end else if (press[0] != press[1]) begin
            m[d]   = (press[0] != 0) ? (m[d] + 1) % nm[d] : (m[d] + nm[d] - 1) % nm[d];
            chg[d] = 1;
         end else begin
            chg[d] = 0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            s1[k] = 1; s2[k] = 1; deb[k] = 1;
            last_agree[k] = edge_no; fell[k] = 0; press[k] = 0;
         end else begin
            press[k] = fell[k];
            if (s2[k] == deb[k]) begin
               last_agree[k] = edge_no;
               fell[k] = 0;
            end else if (edge_no - last_agree[k] >= DC) begin
               deb[k] = s2[k];
               last_agree[k] = edge_no;
               fell[k] = (deb[k] == 0) ? 1 : 0;
            end else begin
               fell[k] = 0;
            end
            s2[k] = s1[k];
            s1[k] = raw[k];
         end
      end
   endtask

   task automatic tick(input logic rst, input logic kn, input logic kp);
      reset = rst;
      raw_n = kn;
      raw_p = kp;
      @(posedge clk);
      model_step(rst, kn, kp);
      #1;
      cyc++;
      if (bus_a.mode_changed === 1'b1) begin
         pulses_a++;
         if (first_pulse < 0) first_pulse = cyc;
      end
      chk("mode_a", 32'(bus_a.mode), m[0]);
      chk("changed_a", 32'(bus_a.mode_changed), chg[0]);
      chk("mode_b", 32'(bus_b.mode), m[1]);
      chk("changed_b", 32'(bus_b.mode_changed), chg[1]);
   endtask

   task automatic repeat_tick(input int n, input logic rst, input logic kn, input logic kp);
      for (int i = 0; i < n; i++) tick(rst, kn, kp);
   endtask

   task automatic clear_pulses();
      pulses_a = 0;
      first_pulse = -1;
   endtask

   initial begin
      int t0;
      int mode_before;
      int hold;
      logic kn;
      logic kp;

      reset = 1'b1;
      raw_n = 1'b1;
      raw_p = 1'b1;

      // Reset with keys released
      repeat_tick(3, 1'b1, 1'b1, 1'b1);
      chk("reset_mode_a", 32'(bus_a.mode), 0);
      chk("reset_mode_b", 32'(bus_b.mode), 2);
      chk("reset_changed_a", 32'(bus_a.mode_changed), 0);
      repeat_tick(6, 1'b0, 1'b1, 1'b1);

      // Clean next press held 20 cycles, then released
      clear_pulses();
      t0 = cyc;
      repeat_tick(20, 1'b0, 1'b0, 1'b1);
      repeat_tick(10, 1'b0, 1'b1, 1'b1);
      chk("clean_pulses", pulses_a, 1);
      chk("clean_latency", first_pulse - t0, DC + 4);
      chk("clean_mode", 32'(bus_a.mode), 1);

      // Bounce: 2-cycle toggles, then held low
      clear_pulses();
      for (int i = 0; i < 12; i++) tick(1'b0, ((i / 2) % 2) != 0, 1'b1);
      t0 = cyc;
      repeat_tick(20, 1'b0, 1'b0, 1'b1);
      repeat_tick(10, 1'b0, 1'b1, 1'b1);
      chk("bounce_pulses", pulses_a, 1);
      chk("bounce_latency", first_pulse - t0, DC + 4);

      // Wrap upward: four clean next presses
      clear_pulses();
      for (int p = 0; p < 4; p++) begin
         repeat_tick(10, 1'b0, 1'b0, 1'b1);
         repeat_tick(10, 1'b0, 1'b1, 1'b1);
      end
      chk("wrap_pulses", pulses_a, 4);

      // Wrap downward from reset: three prev presses
      repeat_tick(2, 1'b1, 1'b1, 1'b1);
      for (int p = 0; p < 3; p++) begin
         repeat_tick(10, 1'b0, 1'b1, 1'b0);
         repeat_tick(10, 1'b0, 1'b1, 1'b1);
      end
      chk("prev_wrap_a", 32'(bus_a.mode), 1);
      chk("prev_wrap_b", 32'(bus_b.mode), 2);

      // Both keys on the same cycle cancel
      clear_pulses();
      mode_before = int'(bus_a.mode);
      repeat_tick(20, 1'b0, 1'b0, 1'b0);
      repeat_tick(10, 1'b0, 1'b1, 1'b1);
      chk("simul_pulses", pulses_a, 0);
      chk("simul_mode", 32'(bus_a.mode), mode_before);

      // One cycle apart: two opposite steps
      clear_pulses();
      tick(1'b0, 1'b0, 1'b1);
      repeat_tick(20, 1'b0, 1'b0, 1'b0);
      repeat_tick(10, 1'b0, 1'b1, 1'b1);
      chk("skew_pulses", pulses_a, 2);
      chk("skew_mode", 32'(bus_a.mode), mode_before);

      // Reset mid-press with the key held low
      clear_pulses();
      repeat_tick(4, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      t0 = cyc;
      repeat_tick(20, 1'b0, 1'b0, 1'b1);
      repeat_tick(10, 1'b0, 1'b1, 1'b1);
      chk("midreset_pulses", pulses_a, 1);
      chk("midreset_latency", first_pulse - t0, DC + 4);
      chk("midreset_mode", 32'(bus_a.mode), 1);

      // Random key segments with occasional reset
      kn = 1'b1;
      kp = 1'b1;
      for (int seg = 0; seg < 150; seg++) begin
         if ($urandom_range(0, 3) == 0) kn = ~kn;
         if ($urandom_range(0, 3) == 0) kp = ~kp;
         hold = int'($urandom_range(1, 10));
         for (int i = 0; i < hold; i++) tick($urandom_range(0, 60) == 0, kn, kp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
